// File: rtl/fare_pkg.sv
// Shared types and constants for the taxi-meter fare display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package fare_pkg;

  localparam int CHARGE_W   = 12;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fare_display_bin2bcd12.sv
// Sequential double-dabble: 12-bit binary to 4 BCD digits.
// One sample cycle, 12 shift cycles, one load cycle.
module bin2bcd12
  import fare_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [CHARGE_W-1:0] bin,
  output logic                busy,
  output logic [BCD_W-1:0]    bcd,
  output logic                done
);

  conv_state_t state, state_nxt;
  logic [BCD_W+CHARGE_W-1:0] sr, adj;
  logic [3:0] bit_cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      sr      <= {{BCD_W{1'b0}}, bin};
      bit_cnt <= '0;
    end else if (state == ST_SHIFT) begin
      sr      <= {adj[BCD_W+CHARGE_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // add-3 on every BCD nibble that would overflow past 9 when doubled
  always_comb begin
    adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[CHARGE_W+4*i +: 4] >= 4'd5) begin
        adj[CHARGE_W+4*i +: 4] = sr[CHARGE_W+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 4'd11) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_LOAD);
    bcd  = sr[BCD_W+CHARGE_W-1:CHARGE_W];
  end

endmodule

// File: rtl/fare_display.sv
// Fare display driver: change-triggered BCD conversion, 4-digit
// multiplexed common-anode scan, leading-zero blanking, pause blink.
module fare_display
  import fare_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_SCANS = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHARGE_W-1:0] Charge,
  input  logic                Pause,
  output logic [6:0]          SEG,
  output logic [3:0]          AN,
  output logic                DP,
  output logic                busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [CHARGE_W-1:0] last_val;
  logic [BCD_W-1:0] digits, bcd;
  logic start, done;

  logic [SW-1:0] scan_cnt;
  logic [1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic blank_phase;
  logic scan_wrap, frame_wrap;

  logic [3:0] nib;
  logic lead_blank;
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;

  // busy is low only in IDLE, so this samples Charge only there
  assign start = (Charge != last_val) && !busy;
  assign DP    = 1'b1;

  bin2bcd12 u_conv (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .bin   (Charge),
    .busy  (busy),
    .bcd   (bcd),
    .done  (done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_val <= '0;
      digits   <= '0;
    end else begin
      if (start) last_val <= Charge;
      if (done) digits <= bcd;
    end
  end

  assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (idx == 2'd3);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      scan_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blank_phase <= 1'b0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      if (scan_wrap) idx <= idx + 2'd1;
      if (!Pause) begin
        frame_cnt   <= '0;
        blank_phase <= 1'b0;
      end else if (frame_wrap) begin
        if (frame_cnt == FW'(BLINK_SCANS - 1)) begin
          frame_cnt   <= '0;
          blank_phase <= ~blank_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_comb begin
    nib        = digits[{idx, 2'b00} +: 4];
    lead_blank = 1'b0;
    case (idx)
      2'd1:    lead_blank = (digits[15:4] == 12'd0);
      2'd2:    lead_blank = (digits[15:8] == 8'd0);
      2'd3:    lead_blank = (digits[15:12] == 4'd0);
      default: lead_blank = 1'b0;
    endcase
    seg_nxt = lead_blank ? SEG_BLANK : seg_code(nib);
    an_nxt  = (Pause && blank_phase) ? 4'hF : ~(4'b0001 << idx);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      SEG <= SEG_BLANK;
      AN  <= 4'hF;
    end else begin
      SEG <= seg_nxt;
      AN  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_fare_display.sv
// Bench for fare_display: decimal reference model plus directed scenarios.
module tb_fare_display;

  localparam int SD = 4;
  localparam int BS = 2;
  localparam logic [6:0] TAB [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [11:0] Charge = 12'd0;
  logic Pause = 1'b0;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic DP, busy;

  int total = 0;
  int bad = 0;

  fare_display #(.SCAN_DIV(SD), .BLINK_SCANS(BS)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Charge (Charge),
    .Pause  (Pause),
    .SEG    (SEG),
    .AN     (AN),
    .DP     (DP),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  // reference model: decimal arithmetic on the displayed value
  int n, shown, m_last, conv_end, pframes, ix;
  bit conv, bl;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'hF;
  logic e_busy = 1'b0;

  function automatic logic [6:0] seg_of(int v, int i);
    int p;
    p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
    if (i > 0 && v < p) return 7'h7F;
    return TAB[(v / p) % 10];
  endfunction

  always @(posedge CLK) begin
    if (!RST) begin
      n = 0; shown = 0; m_last = 0; conv = 0;
      conv_end = 0; pframes = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_busy = 1'b0;
    end else begin
      n++;
      ix = ((n - 1) / SD) % 4;
      bl = ((pframes / BS) % 2) == 1;
      e_an = (Pause && bl) ? 4'hF : ~(4'b0001 << ix);
      e_seg = seg_of(shown, ix);
      if (conv && n == conv_end) begin
        shown = m_last;
        conv = 0;
      end else if (!conv && int'(Charge) != m_last) begin
        m_last = int'(Charge);
        conv = 1;
        conv_end = n + 13;
      end
      e_busy = conv;
      if (!Pause) pframes = 0;
      else if (n % (4 * SD) == 0) pframes++;
    end
  end

  task automatic capture(output logic [27:0] s);
    s = 'x;
    for (int c = 0; c < 4 * SD; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++)
        if (AN === 4'(~(4'b0001 << i))) s[i*7 +: 7] = SEG;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; Charge = 12'd0; Pause = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({SEG, AN, busy, DP} !== {7'h7F, 4'hF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: seg=%h an=%b busy=%b dp=%b want 7f 1111 0 1",
               SEG, AN, busy, DP);
    end
    RST = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      total++;
      if (AN !== 4'(~(4'b0001 << (c / 4)))) begin
        bad++;
        $display("FAIL scan_an c=%0d: an=%b", c, AN);
      end
      total++;
      if (SEG !== ((c < 4) ? 7'h40 : 7'h7F)) begin
        bad++;
        $display("FAIL scan_seg c=%0d: seg=%h", c, SEG);
      end
    end
  endtask

  task automatic test_conv();
    int cnt;
    logic [27:0] s;
    cnt = 0;
    Charge = 12'd300;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (busy === 1'b1) cnt++;
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL conv_model: got %h %b %b want %h %b %b",
                 SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    total++;
    if (cnt != 13) begin
      bad++;
      $display("FAIL conv_busy_len: got %0d want 13", cnt);
    end
    capture(s);
    total++;
    if (s !== {7'h7F, 7'h30, 7'h40, 7'h40}) begin
      bad++;
      $display("FAIL conv_300: got %h want %h", s, {7'h7F, 7'h30, 7'h40, 7'h40});
    end
  endtask

  task automatic test_max();
    logic [27:0] s;
    Charge = 12'd4095;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL max_model: got %h %b %b want %h %b %b",
                 SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    capture(s);
    total++;
    if (s !== {7'h19, 7'h40, 7'h10, 7'h12}) begin
      bad++;
      $display("FAIL max_4095: got %h want %h", s, {7'h19, 7'h40, 7'h10, 7'h12});
    end
    Charge = 12'd0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL zero_model: got %h %b %b want %h %b %b",
                 SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    capture(s);
    total++;
    if (s !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      bad++;
      $display("FAIL zero_blank: got %h want %h", s, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
  endtask

  task automatic test_back_to_back();
    logic b13, b14;
    logic [27:0] s;
    b13 = 1'bx; b14 = 1'bx;
    Charge = 12'd300;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (j == 4) Charge = 12'd310;
      if (j == 13) b13 = busy;
      if (j == 14) b14 = busy;
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL b2b_model j=%0d: got %h %b %b want %h %b %b",
                 j, SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    total++;
    if ({b13, b14} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_restart: busy@13,14 got %b want 01", {b13, b14});
    end
    capture(s);
    total++;
    if (s !== {7'h7F, 7'h30, 7'h79, 7'h40}) begin
      bad++;
      $display("FAIL b2b_310: got %h want %h", s, {7'h7F, 7'h30, 7'h79, 7'h40});
    end
  endtask

  task automatic test_pause();
    bit rec [200];
    int a, fl, vl;
    bit found;
    Charge = 12'd1200;
    repeat (20) @(negedge CLK);
    Pause = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      rec[c] = (AN === 4'hF);
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL pause_model c=%0d: got %h %b %b want %h %b %b",
                 c, SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    a = 0;
    while (a < 200 && !rec[a]) a++;
    fl = 0;
    while (a < 200 && rec[a]) begin fl++; a++; end
    vl = 0;
    while (a < 200 && !rec[a]) begin vl++; a++; end
    total++;
    if (fl != 32 || vl != 32) begin
      bad++;
      $display("FAIL pause_blink: blank=%0d show=%0d want 32 32", fl, vl);
    end
    found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge CLK);
      if (AN === 4'hF) found = 1;
    end
    Pause = 1'b0;
    @(negedge CLK);
    total++;
    if (!found || AN === 4'hF || {SEG, AN} !== {e_seg, e_an}) begin
      bad++;
      $display("FAIL pause_release: found=%0d an=%b want %b", found, AN, e_an);
    end
  endtask

  task automatic test_reset_mid();
    logic b0, b13;
    logic [27:0] s;
    Charge = 12'd777;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({SEG, AN, busy} !== {7'h7F, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid: seg=%h an=%b busy=%b want 7f 1111 0", SEG, AN, busy);
    end
    RST = 1'b1;
    b0 = 1'bx; b13 = 1'bx;
    for (int j = 0; j < 14; j++) begin
      @(negedge CLK);
      if (j == 0) b0 = busy;
      if (j == 13) b13 = busy;
      total++;
      if ({SEG, AN, busy} !== {e_seg, e_an, e_busy}) begin
        bad++;
        $display("FAIL rst_model j=%0d: got %h %b %b want %h %b %b",
                 j, SEG, AN, busy, e_seg, e_an, e_busy);
      end
    end
    total++;
    if ({b0, b13} !== 2'b10) begin
      bad++;
      $display("FAIL rst_reconv: busy@0,13 got %b want 10", {b0, b13});
    end
    capture(s);
    total++;
    if (s !== {7'h7F, 7'h78, 7'h78, 7'h78}) begin
      bad++;
      $display("FAIL rst_777: got %h want %h", s, {7'h7F, 7'h78, 7'h78, 7'h78});
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 40; it++) begin
      Charge = 12'($urandom_range(0, 4095));
      Pause = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        @(negedge CLK);
        total++;
        if ({SEG, AN, busy, DP} !== {e_seg, e_an, e_busy, 1'b1}) begin
          bad++;
          $display("FAIL rand_model it=%0d: got %h %b %b %b want %h %b %b 1",
                   it, SEG, AN, busy, DP, e_seg, e_an, e_busy);
        end
      end
    end
    Pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conv();
    test_max();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
